matrix_frame_scheduler: RTL and testbench

MATRIX_FRAME_SCHEDULER -- requirements
Module: matrix_frame_scheduler

---
 rtl/matrix_frame_scheduler.sv | 121 ++++++++++++
 tb/tb_matrix_frame_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/matrix_frame_scheduler.sv
// matrix_frame_scheduler
//   Drives an 8x8 LED matrix from a double-buffered 64-bit frame store.
//   Two requesters (A, B) offer frames via valid/ready handshakes; a
//   round-robin arbiter accepts at most one frame per cycle into the
//   pending buffer. The pending frame is swapped into the display buffer
//   at the end of a full scan (row 7 terminal count), so a frame is never
//   torn mid-scan.
//
// Ports
//   CLK, RST          clock; synchronous active-high reset
//   a_valid/a_data    requester A frame offer (bit r*8+c = row r, col c)
//   a_ready           requester A accepted this cycle (combinational)
//   b_valid/b_data    requester B frame offer
//   b_ready           requester B accepted this cycle (combinational)
//   oe                display enable; blanks rows/columns when low
//   rows              registered one-hot row select
//   columns           registered column data of the selected row
//   frame_sync        one-cycle pulse following a buffer swap
//   last_grant        requester of the most recently accepted frame (0=A, 1=B)

module matrix_frame_scheduler #(
  parameter int ROW_DIV = 65536
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        a_valid,
  input  logic [63:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [63:0] b_data,
  output logic        b_ready,
  input  logic        oe,
  output logic [7:0]  rows,
  output logic [7:0]  columns,
  output logic        frame_sync,
  output logic        last_grant
);

  // 24 bits covers the full legal ROW_DIV range (terminal count <= 2^24-1).
  localparam logic [23:0] PRESC_TC = 24'(ROW_DIV - 1);

  logic [63:0] disp;
  logic [63:0] pend;
  logic        pend_full;
  logic [23:0] presc;
  logic [2:0]  row_idx;

  logic        tick;
  logic        wrap;
  logic        xfer_a;
  logic        xfer_b;
  logic [63:0] xfer_data;

  assign tick = (presc == PRESC_TC);
  assign wrap = tick && (row_idx == 3'd7);

  // Round-robin: when both offer, the requester not granted last time wins.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!pend_full) begin
      a_ready = a_valid && (!b_valid || last_grant);
      b_ready = b_valid && (!a_valid || !last_grant);
    end
  end

  assign xfer_a    = a_valid && a_ready;
  assign xfer_b    = b_valid && b_ready;
  assign xfer_data = xfer_b ? b_data : a_data;

  // Scan timing runs continuously, independent of oe, so re-enabling the
  // display resumes at the row the scan would have reached anyway.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc   <= '0;
      row_idx <= '0;
    end else if (tick) begin
      presc   <= '0;
      row_idx <= row_idx + 3'd1;
    end else begin
      presc   <= presc + 24'd1;
    end
  end

  // A transfer is only possible with pend_full low, so it can never collide
  // with the swap that clears pend_full.
  always_ff @(posedge CLK) begin
    if (RST) begin
      disp       <= '0;
      pend       <= '0;
      pend_full  <= 1'b0;
      last_grant <= 1'b1;
      frame_sync <= 1'b0;
    end else begin
      frame_sync <= wrap && pend_full;
      if (wrap && pend_full) begin
        disp      <= pend;
        pend_full <= 1'b0;
      end
      if (xfer_a || xfer_b) begin
        pend       <= xfer_data;
        pend_full  <= 1'b1;
        last_grant <= xfer_b;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rows    <= 8'h00;
      columns <= 8'h00;
    end else if (oe) begin
      rows    <= 8'h01 << row_idx;
      columns <= disp[{row_idx, 3'b000} +: 8];
    end else begin
      rows    <= 8'h00;
      columns <= 8'h00;
    end
  end

endmodule

// File: tb/tb_matrix_frame_scheduler.sv
// tb_matrix_frame_scheduler
//   Directed bench for matrix_frame_scheduler with ROW_DIV=4, so one row
//   dwell is 4 cycles and a full frame scan is 32 cycles. cyc counts rising
//   edges since the last reset edge; frame wraps fall on multiples of 32.

module tb_matrix_frame_scheduler;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        a_valid = 1'b0;
  logic [63:0] a_data = '0;
  logic        a_ready;
  logic        b_valid = 1'b0;
  logic [63:0] b_data = '0;
  logic        b_ready;
  logic        oe = 1'b1;
  logic [7:0]  rows;
  logic [7:0]  columns;
  logic        frame_sync;
  logic        last_grant;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [63:0] p1 = 64'h8040201008040201;
  logic [63:0] f2 = 64'h0102030405060708;
  logic [63:0] f3 = 64'h1122334455667788;
  logic [63:0] f4 = 64'hF0E0D0C0B0A09080;
  logic [63:0] f5 = 64'hDEADBEEFCAFEF00D;
  logic [63:0] ga = 64'h00000000000000AA;
  logic [63:0] gb = 64'h00000000000000BB;

  matrix_frame_scheduler #(.ROW_DIV(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .a_valid    (a_valid),
    .a_data     (a_data),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .oe         (oe),
    .rows       (rows),
    .columns    (columns),
    .frame_sync (frame_sync),
    .last_grant (last_grant)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    cyc++;
    #1;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) cycle();
  endtask

  initial begin
    // reset
    cycle();
    cycle();
    check_val("rst_rows", rows, 8'h00);
    check_val("rst_cols", columns, 8'h00);
    check_val("rst_fsync", frame_sync, 1'b0);
    check_val("rst_lgrant", last_grant, 1'b1);
    check_val("idle_a_ready", a_ready, 1'b0);
    check_val("idle_b_ready", b_ready, 1'b0);
    RST = 1'b0;
    cyc = 0;

    // Scenario 1: single frame, scanned after the first wrap
    a_valid = 1'b1;
    a_data  = p1;
    #1;
    check_val("s1_a_ready", a_ready, 1'b1);
    check_val("s1_b_ready", b_ready, 1'b0);
    cycle();
    a_valid = 1'b0;
    check_val("s1_rows_first", rows, 8'h01);
    check_val("s1_cols_first", columns, 8'h00);
    check_val("s1_lgrant", last_grant, 1'b0);
    run_to(31);
    check_val("s1_no_sync_early", frame_sync, 1'b0);
    run_to(32);
    check_val("s1_sync", frame_sync, 1'b1);
    check_val("s1_rows_pre", rows, 8'h80);
    check_val("s1_cols_pre", columns, 8'h00);
    run_to(33);
    check_val("s1_sync_drop", frame_sync, 1'b0);
    for (int r = 0; r < 8; r++) begin
      run_to(33 + 4 * r);
      check_val("s1_rows", rows, 8'h01 << r);
      check_val("s1_cols", columns, p1[r*8 +: 8]);
    end

    // Scenario 3: back-to-back frames from A
    run_to(62);
    a_valid = 1'b1;
    a_data  = f2;
    #1;
    check_val("s3_first_ready", a_ready, 1'b1);
    cycle();
    a_data = f3;
    #1;
    check_val("s3_second_held", a_ready, 1'b0);
    run_to(64);
    check_val("s3_sync", frame_sync, 1'b1);
    check_val("s3_ready_back", a_ready, 1'b1);
    cycle();
    a_valid = 1'b0;
    check_val("s3_sync_drop", frame_sync, 1'b0);
    check_val("s3_rows0", rows, 8'h01);
    check_val("s3_f2_row0", columns, f2[7:0]);
    run_to(69);
    check_val("s3_f2_row1", columns, f2[15:8]);
    run_to(96);
    check_val("s3_sync2", frame_sync, 1'b1);
    run_to(97);
    check_val("s3_f3_row0", columns, f3[7:0]);

    // Scenario 4: transfer on the wrap cycle itself
    run_to(127);
    a_valid = 1'b1;
    a_data  = f4;
    #1;
    check_val("s4_ready", a_ready, 1'b1);
    cycle();
    a_valid = 1'b0;
    check_val("s4_no_sync", frame_sync, 1'b0);
    run_to(129);
    check_val("s4_old_disp", columns, f3[7:0]);
    run_to(160);
    check_val("s4_sync_next", frame_sync, 1'b1);
    run_to(161);
    check_val("s4_new_disp", columns, f4[7:0]);

    // Scenario 5: oe dropped mid-row, scan keeps running
    run_to(170);
    check_val("s5_rows_before", rows, 8'h04);
    oe = 1'b0;
    cycle();
    check_val("s5_rows_off", rows, 8'h00);
    check_val("s5_cols_off", columns, 8'h00);
    run_to(178);
    check_val("s5_rows_still_off", rows, 8'h00);
    oe = 1'b1;
    cycle();
    check_val("s5_rows_resume", rows, 8'h10);
    check_val("s5_cols_resume", columns, f4[39:32]);

    // Scenario 6: reset while a frame is pending mid-frame
    run_to(180);
    a_valid = 1'b1;
    a_data  = f5;
    #1;
    check_val("s6_pend_ready", a_ready, 1'b1);
    cycle();
    a_valid = 1'b0;
    run_to(185);
    RST = 1'b1;
    cycle();
    check_val("s6_rows", rows, 8'h00);
    check_val("s6_cols", columns, 8'h00);
    check_val("s6_fsync", frame_sync, 1'b0);
    check_val("s6_lgrant", last_grant, 1'b1);
    RST = 1'b0;
    cyc = 0;
    run_to(32);
    check_val("s6_no_sync", frame_sync, 1'b0);
    run_to(33);
    check_val("s6_rows_restart", rows, 8'h01);
    check_val("s6_disp_cleared", columns, 8'h00);

    // Scenario 2: both valid continuously, alternating grants from A
    a_valid = 1'b1;
    a_data  = ga;
    b_valid = 1'b1;
    b_data  = gb;
    #1;
    check_val("s2_g1_a", a_ready, 1'b1);
    check_val("s2_g1_b", b_ready, 1'b0);
    cycle();
    check_val("s2_lg1", last_grant, 1'b0);
    check_val("s2_full_a", a_ready, 1'b0);
    check_val("s2_full_b", b_ready, 1'b0);
    run_to(64);
    check_val("s2_g2_a", a_ready, 1'b0);
    check_val("s2_g2_b", b_ready, 1'b1);
    cycle();
    check_val("s2_lg2", last_grant, 1'b1);
    check_val("s2_disp_a", columns, ga[7:0]);
    run_to(96);
    check_val("s2_g3_a", a_ready, 1'b1);
    check_val("s2_g3_b", b_ready, 1'b0);
    cycle();
    a_valid = 1'b0;
    b_valid = 1'b0;
    check_val("s2_lg3", last_grant, 1'b0);
    check_val("s2_disp_b", columns, gb[7:0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
